// File: rtl/reg_scoreboard.sv
// Issue-side register scoreboard: counts outstanding writes per register and
// stalls issue on RAW/WAW hazards, with a same-cycle writeback bypass.
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 2,
    parameter int TOT_W    = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic [ADDR_W-1:0] issue_rs_i,
    input  logic              issue_use_rs_i,
    input  logic [ADDR_W-1:0] issue_rt_i,
    input  logic              issue_use_rt_i,
    input  logic [ADDR_W-1:0] issue_rd_i,
    input  logic              issue_wr_i,
    input  logic              wb_valid_i,
    input  logic [ADDR_W-1:0] wb_rd_i,
    input  logic              flush_i,
    output logic              rs_busy_o,
    output logic              rt_busy_o,
    output logic [TOT_W-1:0]  outstanding_o,
    output logic              err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    logic [CNT_W-1:0] pend_q [NUM_REGS];
    logic [CNT_W-1:0] pend_d [NUM_REGS];
    logic [CNT_W-1:0] eff    [NUM_REGS];
    logic [TOT_W-1:0] tot_q, tot_d;
    logic             err_q, err_d;

    logic             wbHit;
    logic             wbErr;
    logic             wrTracked;
    logic             rdFull;
    logic             totSat;
    logic [TOT_W-1:0] totEff;
    logic             ready;
    logic             incr;
    logic             sameReg;

    // A writeback retiring this cycle already counts as done for hazard checks.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            eff[r] = pend_q[r];
            if (wb_valid_i && (wb_rd_i == ADDR_W'(r)) && (pend_q[r] != '0)) begin
                eff[r] = pend_q[r] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        wbHit     = wb_valid_i && (wb_rd_i != '0) && (pend_q[wb_rd_i] != '0);
        wbErr     = wb_valid_i && (wb_rd_i != '0) && (pend_q[wb_rd_i] == '0);
        wrTracked = issue_wr_i && (issue_rd_i != '0);
        rs_busy_o = issue_use_rs_i && (eff[issue_rs_i] != '0);
        rt_busy_o = issue_use_rt_i && (eff[issue_rt_i] != '0);
        rdFull    = wrTracked && (eff[issue_rd_i] == CNT_MAX);
        totEff    = tot_q - TOT_W'(wbHit);
        totSat    = wrTracked && (totEff == TOT_MAX);
        ready     = !rst_i && !flush_i && !rs_busy_o && !rt_busy_o && !rdFull && !totSat;
        incr      = issue_valid_i && ready && wrTracked;
        sameReg   = incr && wbHit && (wb_rd_i == issue_rd_i);
    end

    assign issue_ready_o = ready;
    assign outstanding_o = tot_q;
    assign err_o         = err_q;

    // Flush wins over everything except reset; an issue and a writeback to
    // the same register cancel out.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            pend_d[r] = pend_q[r];
        end
        tot_d = tot_q;
        err_d = err_q;
        if (flush_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_d[r] = '0;
            end
            tot_d = '0;
        end else begin
            if (incr && !sameReg) begin
                pend_d[issue_rd_i] = pend_q[issue_rd_i] + CNT_W'(1);
            end
            if (wbHit && !sameReg) begin
                pend_d[wb_rd_i] = pend_q[wb_rd_i] - CNT_W'(1);
            end
            tot_d = tot_q + TOT_W'(incr) - TOT_W'(wbHit);
            if (wbErr) begin
                err_d = 1'b1;
            end
        end
        pend_d[0] = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_q[r] <= '0;
            end
            tot_q <= '0;
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_q[r] <= pend_d[r];
            end
            tot_q <= tot_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed hazard scenarios plus
// random traffic compared against an integer-count reference model.
module tb_reg_scoreboard;

    localparam int NR = 32;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       issue_valid_i;
    logic       issue_ready_o;
    logic [4:0] issue_rs_i;
    logic       issue_use_rs_i;
    logic [4:0] issue_rt_i;
    logic       issue_use_rt_i;
    logic [4:0] issue_rd_i;
    logic       issue_wr_i;
    logic       wb_valid_i;
    logic [4:0] wb_rd_i;
    logic       flush_i;
    logic       rs_busy_o;
    logic       rt_busy_o;
    logic [5:0] outstanding_o;
    logic       err_o;

    reg_scoreboard dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .issue_valid_i  (issue_valid_i),
        .issue_ready_o  (issue_ready_o),
        .issue_rs_i     (issue_rs_i),
        .issue_use_rs_i (issue_use_rs_i),
        .issue_rt_i     (issue_rt_i),
        .issue_use_rt_i (issue_use_rt_i),
        .issue_rd_i     (issue_rd_i),
        .issue_wr_i     (issue_wr_i),
        .wb_valid_i     (wb_valid_i),
        .wb_rd_i        (wb_rd_i),
        .flush_i        (flush_i),
        .rs_busy_o      (rs_busy_o),
        .rt_busy_o      (rt_busy_o),
        .outstanding_o  (outstanding_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit       v;
        bit [4:0] rs;
        bit       urs;
        bit [4:0] rt;
        bit       urt;
        bit [4:0] rd;
        bit       wr;
        bit       wbv;
        bit [4:0] wbrd;
        bit       fl;
    } stim_t;

    int   mPend [NR];
    bit   mErr;
    int   errors = 0;
    int   checks = 0;
    logic lastReady;
    logic lastRsBusy;

    function automatic stim_t idle();
        stim_t s;
        s.v = 0; s.rs = 0; s.urs = 0; s.rt = 0; s.urt = 0;
        s.rd = 0; s.wr = 0; s.wbv = 0; s.wbrd = 0; s.fl = 0;
        return s;
    endfunction

    function automatic stim_t iss(input bit [4:0] rd);
        stim_t s = idle();
        s.v = 1; s.wr = 1; s.rd = rd;
        return s;
    endfunction

    function automatic stim_t wbOnly(input bit [4:0] rd);
        stim_t s = idle();
        s.wbv = 1; s.wbrd = rd;
        return s;
    endfunction

    function automatic int modelEff(input int r, input stim_t s);
        return mPend[r] - ((s.wbv && int'(s.wbrd) == r && mPend[r] > 0) ? 1 : 0);
    endfunction

    function automatic int modelTot();
        int t = 0;
        for (int r = 1; r < NR; r++) t += mPend[r];
        return t;
    endfunction

    function automatic bit modelRsBusy(input stim_t s);
        return s.urs && modelEff(int'(s.rs), s) > 0;
    endfunction

    function automatic bit modelRtBusy(input stim_t s);
        return s.urt && modelEff(int'(s.rt), s) > 0;
    endfunction

    function automatic bit modelReady(input stim_t s);
        bit writes = s.wr && s.rd != 0;
        int wbDec  = (s.wbv && s.wbrd != 0 && mPend[s.wbrd] > 0) ? 1 : 0;
        if (s.fl) return 0;
        if (modelRsBusy(s) || modelRtBusy(s)) return 0;
        if (writes && modelEff(int'(s.rd), s) == 3) return 0;
        if (writes && (modelTot() - wbDec + 1) > 63) return 0;
        return 1;
    endfunction

    task automatic modelUpdate(input stim_t s, input bit accepted);
        if (s.fl) begin
            for (int r = 0; r < NR; r++) mPend[r] = 0;
        end else begin
            if (s.wbv && s.wbrd != 0) begin
                if (mPend[s.wbrd] > 0) mPend[s.wbrd]--;
                else mErr = 1;
            end
            if (accepted && s.wr && s.rd != 0) mPend[s.rd]++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        bit expReady;
        @(negedge clk_i);
        issue_valid_i  = s.v;
        issue_rs_i     = s.rs;
        issue_use_rs_i = s.urs;
        issue_rt_i     = s.rt;
        issue_use_rt_i = s.urt;
        issue_rd_i     = s.rd;
        issue_wr_i     = s.wr;
        wb_valid_i     = s.wbv;
        wb_rd_i        = s.wbrd;
        flush_i        = s.fl;
        #1;
        expReady = modelReady(s);
        checkOutput("ready", issue_ready_o, expReady);
        checkOutput("rs_busy", rs_busy_o, modelRsBusy(s));
        checkOutput("rt_busy", rt_busy_o, modelRtBusy(s));
        lastReady  = issue_ready_o;
        lastRsBusy = rs_busy_o;
        @(posedge clk_i);
        modelUpdate(s, s.v && expReady);
        #1;
        checkOutput("outstanding", outstanding_o, modelTot());
        checkOutput("err", err_o, mErr);
    endtask

    initial begin
        stim_t s;
        for (int r = 0; r < NR; r++) mPend[r] = 0;
        mErr = 0;
        s = idle();
        rst_i = 1'b1;
        issue_valid_i = 0; issue_rs_i = 0; issue_use_rs_i = 0; issue_rt_i = 0;
        issue_use_rt_i = 0; issue_rd_i = 0; issue_wr_i = 0; wb_valid_i = 0;
        wb_rd_i = 0; flush_i = 0;
        #12;
        checkOutput("reset_ready", issue_ready_o, 0);
        checkOutput("reset_outstanding", outstanding_o, 0);
        checkOutput("reset_err", err_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // RAW on r5, then resolved by a same-cycle writeback
        applyStimulus(iss(5));
        s = idle(); s.v = 1; s.urs = 1; s.rs = 5;
        applyStimulus(s);
        checkOutput("raw_stall_ready", lastReady, 0);
        checkOutput("raw_stall_busy", lastRsBusy, 1);
        s.wbv = 1; s.wbrd = 5;
        applyStimulus(s);
        checkOutput("raw_bypass_ready", lastReady, 1);

        // WAW saturation on r7
        for (int i = 0; i < 3; i++) applyStimulus(iss(7));
        applyStimulus(iss(7));
        checkOutput("waw_full_ready", lastReady, 0);
        applyStimulus(iss(8));
        checkOutput("waw_other_ready", lastReady, 1);
        for (int i = 0; i < 3; i++) applyStimulus(wbOnly(7));
        applyStimulus(wbOnly(8));

        // Simultaneous issue and writeback on r9
        applyStimulus(iss(9));
        s = iss(9); s.wbv = 1; s.wbrd = 9;
        applyStimulus(s);
        checkOutput("simul_outstanding", outstanding_o, 1);
        applyStimulus(wbOnly(9));

        // r0 is never tracked; stray writeback sets sticky error
        applyStimulus(iss(0));
        checkOutput("r0_outstanding", outstanding_o, 0);
        applyStimulus(wbOnly(12));
        checkOutput("err_set", err_o, 1);
        applyStimulus(idle());
        checkOutput("err_sticky", err_o, 1);

        // Flush with a concurrent issue
        applyStimulus(iss(4));
        applyStimulus(iss(4));
        applyStimulus(iss(6));
        s = iss(4); s.fl = 1;
        applyStimulus(s);
        checkOutput("flush_ready", lastReady, 0);
        checkOutput("flush_outstanding", outstanding_o, 0);

        // Total-count saturation at 63
        for (int r = 1; r <= 21; r++)
            for (int i = 0; i < 3; i++) applyStimulus(iss(5'(r)));
        checkOutput("tot_full", outstanding_o, 63);
        applyStimulus(iss(22));
        checkOutput("tot_sat_ready", lastReady, 0);
        s = iss(22); s.wbv = 1; s.wbrd = 1;
        applyStimulus(s);
        checkOutput("tot_wb_ready", lastReady, 1);
        s = idle(); s.fl = 1;
        applyStimulus(s);

        // Random traffic over a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            s = idle();
            s.v    = ($urandom_range(9, 0) < 7);
            s.wr   = ($urandom_range(9, 0) < 6);
            s.rd   = 5'($urandom_range(7, 0));
            s.urs  = $urandom_range(1, 0);
            s.rs   = 5'($urandom_range(7, 0));
            s.urt  = $urandom_range(1, 0);
            s.rt   = 5'($urandom_range(7, 0));
            s.wbv  = ($urandom_range(9, 0) < 4);
            s.wbrd = 5'($urandom_range(7, 0));
            s.fl   = ($urandom_range(49, 0) == 0);
            applyStimulus(s);
        end

        // Asynchronous reset mid-cycle with r3 pending
        s = idle(); s.fl = 1;
        applyStimulus(s);
        applyStimulus(iss(3));
        checkOutput("pre_reset_outstanding", outstanding_o, 1);
        #1;
        rst_i = 1'b1;
        #1;
        checkOutput("async_outstanding", outstanding_o, 0);
        checkOutput("async_err", err_o, 0);
        checkOutput("async_ready", issue_ready_o, 0);
        for (int r = 0; r < NR; r++) mPend[r] = 0;
        mErr = 0;
        @(negedge clk_i);
        issue_valid_i = 0; issue_wr_i = 0;
        rst_i = 1'b0;
        applyStimulus(iss(3));
        checkOutput("post_reset_outstanding", outstanding_o, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
